// File: rtl/hash_match_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hashchk_pkg
// Purpose  : Shared definitions for the hash match table: command opcodes,
//            control state encoding and the scan-beat helper.
// Revision : 1.0 - initial release
// ============================================================================
package hashchk_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_CHECK = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADD   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Number of scan beats needed to cover the whole table
    function automatic int calc_beats(input int depth, input int lanes);
        return depth / lanes;
    endfunction

    localparam int BEATS = calc_beats(128, 8);

endpackage : hashchk_pkg
`default_nettype wire

// File: rtl/hash_match_table_if.sv
`default_nettype none
// ============================================================================
// Module   : hash_match_table_if
// Purpose  : Command / response bundle of the hash match table.
//            cmd_*  : command handshake (valid/ready), opcode and hash operand
//            rsp_*  : one-cycle completion pulse plus held result fields
//            count  : number of valid entries, busy : !cmd_ready
// Revision : 1.0 - initial release
// ============================================================================
interface hash_match_table_if #(
    parameter int HASH_W = 128,
    parameter int IDX_W  = 7
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [HASH_W-1:0] cmd_hash;
    logic              rsp_valid;
    logic              rsp_match;
    logic [IDX_W-1:0]  rsp_index;
    logic              rsp_full;
    logic [IDX_W:0]    count;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_hash,
        input  cmd_ready, rsp_valid, rsp_match, rsp_index, rsp_full, count, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_hash,
        output cmd_ready, rsp_valid, rsp_match, rsp_index, rsp_full, count, busy
    );
endinterface : hash_match_table_if
`default_nettype wire

// File: rtl/hash_match_table_cmp.sv
`default_nettype none
// ============================================================================
// Module   : hash_cmp_lane
// Purpose  : LANES parallel equality compares of one candidate hash against
//            LANES table entries, gated by a per-lane valid mask.
//            cand_i  : candidate hash       entry_i : LANES entry values
//            valid_i : lane enable mask     hit_o   : per-lane hit vector
//            any_hit_o : OR of hits         first_o : lowest hitting lane
//            Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module hash_cmp_lane #(
    parameter int HASH_W = 128,
    parameter int LANES  = 8,
    parameter int OFF_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  wire logic [HASH_W-1:0]            cand_i,
    input  wire logic [LANES-1:0][HASH_W-1:0] entry_i,
    input  wire logic [LANES-1:0]             valid_i,
    output logic      [LANES-1:0]             hit_o,
    output logic                              any_hit_o,
    output logic      [OFF_W-1:0]             first_o
);

    for (genvar l = 0; l < LANES; l++) begin : g_cmp
        assign hit_o[l] = valid_i[l] && (entry_i[l] == cand_i);
    end

    assign any_hit_o = |hit_o;

    // Walk from the top lane down so the lowest hit wins
    always_comb begin
        first_o = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (hit_o[l]) begin
                first_o = OFF_W'(l);
            end
        end
    end

endmodule : hash_cmp_lane
`default_nettype wire

// File: rtl/hash_match_table.sv
`default_nettype none
// ============================================================================
// Module   : hash_match_table
// Purpose  : Store-and-lookup table of target hashes. ADD appends a hash,
//            CHECK scans LANES entries per beat and reports the lowest match,
//            CLEAR empties the table, NOP just responds.
//            clk, rst : clock and asynchronous active-high reset
//            bus      : command/response interface (slave side)
// Revision : 1.0 - initial release
// ============================================================================
module hash_match_table
    import hashchk_pkg::*;
#(
    parameter int HASH_W = 128,
    parameter int DEPTH  = 128,
    parameter int LANES  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    hash_match_table_if.slave bus
);

    localparam int N_BEATS = calc_beats(DEPTH, LANES);
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int OFF_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W:0] C_DEPTH = (IDX_W + 1)'(DEPTH);

    state_t                       state_q, state_d;
    logic [HASH_W-1:0]            hash_q;
    logic [IDX_W:0]               count_q;
    logic [BEAT_W-1:0]            beat_q;
    logic                         rsp_match_q;
    logic [IDX_W-1:0]             rsp_index_q;
    logic                         rsp_full_q;
    logic [HASH_W-1:0]            mem_q [DEPTH];

    logic                         w_ready;
    logic                         w_accept;
    logic                         w_has_room;
    logic [IDX_W-1:0]             w_base;
    logic [BEAT_W-1:0]            w_last_beat;
    logic                         w_scan_last;
    logic [LANES-1:0][HASH_W-1:0] w_lane_hash;
    logic [LANES-1:0]             w_lane_valid;
    logic [LANES-1:0]             w_hit;
    logic                         w_any_hit;
    logic [OFF_W-1:0]             w_first_off;

    assign w_accept   = bus.cmd_valid && w_ready;
    assign w_has_room = count_q < C_DEPTH;
    assign w_base     = IDX_W'(beat_q) * IDX_W'(LANES);

    // Final beat is the one holding entry count-1; an empty table still
    // takes a single (fully masked) beat.
    assign w_last_beat = (count_q == '0) ? '0
                                         : BEAT_W'((count_q - 1'b1) / LANES);
    assign w_scan_last = (beat_q == w_last_beat);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] w_idx;
        assign w_idx           = w_base + IDX_W'(l);
        assign w_lane_hash[l]  = mem_q[w_idx];
        // Slots at or above count hold stale data and must never hit
        assign w_lane_valid[l] = ({1'b0, w_idx} < count_q);
    end

    hash_cmp_lane #(
        .HASH_W (HASH_W),
        .LANES  (LANES),
        .OFF_W  (OFF_W)
    ) u_cmp (
        .cand_i    (hash_q),
        .entry_i   (w_lane_hash),
        .valid_i   (w_lane_valid),
        .hit_o     (w_hit),
        .any_hit_o (w_any_hit),
        .first_o   (w_first_off)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.cmd_op)
                        OP_ADD:   state_d = ST_ADD;
                        OP_CHECK: state_d = ST_SCAN;
                        OP_CLEAR: state_d = ST_CLEAR;
                        default:  state_d = ST_RESP;
                    endcase
                end
            end
            ST_ADD:   state_d = ST_RESP;
            ST_CLEAR: state_d = ST_RESP;
            ST_SCAN: begin
                if (w_any_hit || w_scan_last) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Ready is gated by rst so nothing can be accepted while reset is held.
    always_comb begin
        w_ready       = (state_q == ST_IDLE) && !rst;
        bus.cmd_ready = w_ready;
        bus.busy      = !w_ready;
        bus.rsp_valid = (state_q == ST_RESP);
    end

    assign bus.rsp_match = rsp_match_q;
    assign bus.rsp_index = rsp_index_q;
    assign bus.rsp_full  = rsp_full_q;
    assign bus.count     = count_q;

    // ---------------- datapath / result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash_q      <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            rsp_match_q <= 1'b0;
            rsp_index_q <= '0;
            rsp_full_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        hash_q <= bus.cmd_hash;
                        beat_q <= '0;
                        if (bus.cmd_op == OP_NOP) begin
                            rsp_match_q <= 1'b0;
                            rsp_index_q <= '0;
                            rsp_full_q  <= 1'b0;
                        end
                    end
                end
                ST_ADD: begin
                    rsp_match_q <= 1'b0;
                    if (w_has_room) begin
                        rsp_index_q <= count_q[IDX_W-1:0];
                        rsp_full_q  <= 1'b0;
                        count_q     <= count_q + 1'b1;
                    end else begin
                        rsp_index_q <= '0;
                        rsp_full_q  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    rsp_full_q <= 1'b0;
                    beat_q     <= beat_q + 1'b1;
                    if (|w_hit) begin
                        rsp_match_q <= 1'b1;
                        rsp_index_q <= w_base + IDX_W'(w_first_off);
                    end else if (w_scan_last) begin
                        rsp_match_q <= 1'b0;
                        rsp_index_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    count_q     <= '0;
                    rsp_match_q <= 1'b0;
                    rsp_index_q <= '0;
                    rsp_full_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Entry storage is intentionally left out of reset
    always_ff @(posedge clk) begin
        if ((state_q == ST_ADD) && w_has_room) begin
            mem_q[count_q[IDX_W-1:0]] <= hash_q;
        end
    end

endmodule : hash_match_table
`default_nettype wire

// File: tb/tb_hash_match_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_match_table
// Purpose  : Scoreboard bench for hash_match_table (HASH_W=128, DEPTH=128,
//            LANES=8). The driver pushes the expected response for each
//            accepted command; a monitor pops and compares on rsp_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hash_match_table;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_CHECK = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    localparam logic [127:0] H0     = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] H1     = 128'hFEDCBA9876543210FEDCBA9876543210;
    localparam logic [127:0] HDUP   = 128'h55555555AAAAAAAA55555555AAAAAAAA;
    localparam logic [127:0] HABS   = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;

    typedef struct {
        logic       m;
        logic [6:0] idx;
        logic       f;
        int         lat;   // 0 = latency not checked
        logic [7:0] cnt;
        longint     t_acc;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   sbq[$];
    int     n_checks;
    int     n_fail;
    longint last_acc_t;
    longint last_rsp_t;

    hash_match_table_if #(.HASH_W(128), .IDX_W(7)) bus ();

    hash_match_table #(
        .HASH_W (128),
        .DEPTH  (128),
        .LANES  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input int i);
        return {32'hDEAD0000 | 32'(i), 32'h12345678, 32'(i * 7), 32'hCAFEF00D};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one command, wait (bounded) for acceptance, push expectation
    task automatic issue(input logic [1:0] op, input logic [127:0] h,
                         input logic m, input logic [6:0] idx, input logic f,
                         input int lat, input logic [7:0] cnt);
        int   w;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_hash  = h;
        w = 0;
        while (!bus.cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            chk("accept_timeout", 1'b0, 1'b1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        last_acc_t = longint'($time);
        e.m = m; e.idx = idx; e.f = f; e.lat = lat; e.cnt = cnt; e.t_acc = last_acc_t;
        sbq.push_back(e);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Monitor: every rsp_valid must correspond to exactly one expectation
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp_valid", 1'b1, 1'b0);
            end else begin
                exp_t   e;
                longint lat;
                e = sbq.pop_front();
                lat = (longint'($time) - e.t_acc - 5) / 10 + 1;
                last_rsp_t = longint'($time);
                chk("rsp_match", bus.rsp_match, e.m);
                chk("rsp_index", bus.rsp_index, e.idx);
                chk("rsp_full",  bus.rsp_full,  e.f);
                chk("count",     bus.count,     e.cnt);
                if (e.lat > 0) chk("latency", lat, e.lat);
            end
        end
    end

    initial begin
        int w;
        n_checks = 0; n_fail = 0; last_acc_t = 0; last_rsp_t = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_hash  = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 1'b0);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_count",     bus.count,     8'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", bus.cmd_ready, 1'b1);

        // Empty table must not match an all-zero hash
        issue(OP_CHECK, '0, 1'b0, 7'd0, 1'b0, 2, 8'd0);

        issue(OP_ADD,   H0, 1'b0, 7'd0, 1'b0, 2, 8'd1);
        issue(OP_ADD,   H1, 1'b0, 7'd1, 1'b0, 2, 8'd2);
        issue(OP_CHECK, H1, 1'b1, 7'd1, 1'b0, 2, 8'd2);
        issue(OP_CHECK, H0, 1'b1, 7'd0, 1'b0, 2, 8'd2);
        issue(OP_NOP,   H0, 1'b0, 7'd0, 1'b0, 0, 8'd2);

        // Fill the table, then overflow
        issue(OP_CLEAR, '0, 1'b0, 7'd0, 1'b0, 2, 8'd0);
        for (int i = 0; i < 128; i++) begin
            issue(OP_ADD, mk(i), 1'b0, 7'(i), 1'b0, 2, 8'(i + 1));
        end
        issue(OP_ADD,   HABS,    1'b0, 7'd0,   1'b1, 2,  8'd128);
        issue(OP_CHECK, mk(127), 1'b1, 7'd127, 1'b0, 17, 8'd128);
        issue(OP_CHECK, HABS,    1'b0, 7'd0,   1'b0, 17, 8'd128);
        issue(OP_CHECK, mk(0),   1'b1, 7'd0,   1'b0, 2,  8'd128);
        issue(OP_CHECK, mk(8),   1'b1, 7'd8,   1'b0, 3,  8'd128);

        // Duplicates at 3 and 40; lowest index wins
        issue(OP_CLEAR, '0, 1'b0, 7'd0, 1'b0, 2, 8'd0);
        for (int i = 0; i <= 40; i++) begin
            issue(OP_ADD, (i == 3 || i == 40) ? HDUP : mk(i), 1'b0, 7'(i), 1'b0, 2, 8'(i + 1));
        end
        issue(OP_CHECK, HDUP,   1'b1, 7'd3,  1'b0, 2, 8'd41);
        issue(OP_CHECK, mk(39), 1'b1, 7'd39, 1'b0, 6, 8'd41);
        issue(OP_CLEAR, '0,     1'b0, 7'd0,  1'b0, 2, 8'd0);
        issue(OP_CHECK, HDUP,   1'b0, 7'd0,  1'b0, 2, 8'd0);
        issue(OP_ADD,   mk(5),  1'b0, 7'd0,  1'b0, 2, 8'd1);

        // Held command must wait for the response edge of the previous one
        issue(OP_CHECK, HABS, 1'b0, 7'd0, 1'b0, 2, 8'd1);
        issue(OP_CHECK, HABS, 1'b0, 7'd0, 1'b0, 2, 8'd1);
        chk("held_accept_time", last_acc_t, last_rsp_t + 15);

        // Reset during a multi-beat scan
        for (int i = 0; i < 20; i++) begin
            issue(OP_ADD, mk(100 + i), 1'b0, 7'(i + 1), 1'b0, 2, 8'(i + 2));
        end
        issue(OP_CHECK, HABS, 1'b0, 7'd0, 1'b0, 4, 8'd21);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        if (sbq.size() > 0) void'(sbq.pop_back());
        #1;
        chk("midreset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midreset_cmd_ready", bus.cmd_ready, 1'b0);
        chk("midreset_count",     bus.count,     8'd0);
        chk("midreset_rsp_match", bus.rsp_match, 1'b0);
        chk("midreset_rsp_index", bus.rsp_index, 7'd0);
        chk("midreset_rsp_full",  bus.rsp_full,  1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", bus.cmd_ready, 1'b1);
        chk("post_reset_count", bus.count,     8'd0);
        issue(OP_CHECK, mk(100), 1'b0, 7'd0, 1'b0, 2, 8'd0);
        issue(OP_ADD,   H1,      1'b0, 7'd0, 1'b0, 2, 8'd1);

        w = 0;
        while (sbq.size() > 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() > 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hash_match_table
`default_nettype wire
